inst_cache_responder: RTL and testbench
=======================================

// Module: inst_cache_responder
// PURPOSE
//  Responder side of the fetch interface: accepts the fetch PC each cycle, returns
//  the 32-bit instruction word, and holds the fetch stage via stall while fetching.
//  Direct-mapped, read-only instruction cache; misses refill a whole line from the
//  backing instruction memory one word per handshake. Sits between fetch and imem.
// PARAMETERS
//  LINES           16   number of cache lines (power of 2, >=2)
//  WORDS_PER_LINE  4    32-bit words per line (power of 2, >=2)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_b         in   1   asynchronous active-low reset
//  fetch_req     in   1   fetch stage requests the instruction at pc this cycle
//  pc            in   32  byte address of the requested instruction
//  flush         in   1   invalidate all lines (e.g. after an imem write)
//  inst          out  32  instruction word; 32'h0 (nop) whenever inst_valid=0
//  inst_valid    out  1   inst holds mem[pc] this cycle
//  stall         out  1   fetch must hold pc (drives the fetch pc enable low)
//  mem_rd_req    out  1   read request to backing memory
//  mem_addr      out  32  word-aligned read address (bits [1:0] = 0)
//  mem_rd_data   in   32  read data from backing memory
//  mem_rd_valid  in   1   mem_rd_data valid; completes the outstanding request
//  hit_count     out  32  saturating count of hit cycles
//  miss_count    out  32  saturating count of misses (one per refill started)
// BEHAVIOUR
//  - Address split: pc[1:0] ignored; offset = next log2(WORDS_PER_LINE) bits;
//    index = next log2(LINES) bits; tag = all remaining upper bits.
//  - Arrays: valid[LINES] flops, tag and data arrays; read is combinational.
//  - States: IDLE, REFILL.
//  - IDLE: hit = fetch_req & valid[idx] & tag match. Hit -> inst_valid=1,
//    inst=data[idx][off], stall=0, same cycle (zero latency).
//    Miss (fetch_req & ~hit) -> stall=1, latch line base of pc, beat=0,
//    miss_count++, next state REFILL. fetch_req=0 -> stall=0, inst_valid=0.
//  - REFILL: stall=1, inst_valid=0. mem_rd_req=1, mem_addr = base + 4*beat.
//    Exactly one outstanding request; req/addr held stable until mem_rd_valid.
//    On mem_rd_valid: write word to data[idx][beat], beat++. On last beat:
//    write tag, set valid[idx] (unless killed), state IDLE. The next cycle
//    re-looks-up pc and hits. Miss latency = WORDS_PER_LINE handshakes + 1 cycle.
//  - mem_rd_req goes low in the cycle after the last mem_rd_valid; mem_rd_valid
//    while mem_rd_req=0 is ignored.
//  - pc changes during REFILL are ignored; the refill always completes for the
//    latched line. Fetch must hold pc while stall=1.
//  - flush: clears all valid bits at the clock edge. In IDLE the same-cycle lookup
//    still uses pre-flush valid bits. In REFILL it sets a kill flag: the refill
//    completes but the line is not marked valid; kill clears on return to IDLE.
//  - Counters: hit_count++ on each IDLE hit cycle; both saturate at 32'hFFFF_FFFF.
//  - Reset (async, rst_b=0): state IDLE, all valid=0, beat=0, kill=0, counters=0,
//    mem_rd_req=0, mem_addr=0, inst=0, inst_valid=0, stall=0. Reset mid-refill
//    abandons the refill; the line stays invalid. Tag and data arrays not reset.
// TESTING
//  1 Cold miss: rst, pc=0x40 fetch_req=1 -> stall=1, mem_addr 0x40,0x44,0x48,0x4C
//    one per handshake; then inst=word at 0x40, inst_valid=1, miss_count=1.
//  2 Line hits: after test 1, pc=0x44,0x48,0x4C back-to-back -> inst_valid=1 each
//    cycle, stall=0, no mem_rd_req, hit_count increments by 3.
//  3 Conflict: pc=0x40 then pc=0x40+16*LINES*4 -> second refills same index; pc=0x40
//    again misses; miss_count=3.
//  4 Memory backpressure: mem_rd_valid delayed 5 cycles per beat -> mem_rd_req and
//    mem_addr stable throughout; stall=1 continuously; data correct after refill.
//  5 Flush during refill: flush on beat 2 -> refill finishes, next pc=0x40 misses
//    again. Flush in IDLE -> all previously hitting lines miss.
//  6 Reset mid-refill: rst_b low on beat 1 -> all outputs at reset values
//    immediately; after release, pc=0x40 misses and refills from beat 0.

Source files
------------

// File: rtl/inst_cache_responder.sv
// Direct-mapped read-only instruction cache between fetch and imem.
// Zero-latency hits; misses refill a whole line one word per memory handshake.
module inst_cache_responder #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        fetch_req,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        stall,
   output logic        mem_rd_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_rd_valid,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   // state  | meaning
   // IDLE   | look up pc each cycle; hit returns data, miss latches line
   // REFILL | fetch latched line from imem, one outstanding word at a time

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(LINES);
   localparam int LINE_W = 30 - OFF_W;
   localparam int TAG_W  = LINE_W - IDX_W;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [OFF_W-1:0]    beat_q, beat_d;
   logic                kill_q, kill_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [31:0]         data_mem [LINES*WORDS_PER_LINE];

   logic [IDX_W-1:0]    lk_idx, rf_idx;
   logic [OFF_W-1:0]    lk_off;
   logic [TAG_W-1:0]    lk_tag, rf_tag;
   logic                lookup, hit, miss, handshake, last_beat, refill_done;
   logic                pc_unused;

   assign lk_off    = pc[2 +: OFF_W];
   assign lk_idx    = pc[2+OFF_W +: IDX_W];
   assign lk_tag    = pc[31 -: TAG_W];
   assign rf_idx    = line_q[IDX_W-1:0];
   assign rf_tag    = line_q[LINE_W-1 -: TAG_W];
   assign pc_unused = ^pc[1:0];

   // rst_b gates the lookup so outputs read as reset values while reset is held
   assign lookup      = fetch_req & rst_b & (state_q == IDLE);
   assign hit         = lookup & valid_q[lk_idx] & (tag_mem[lk_idx] == lk_tag);
   assign miss        = lookup & ~hit;
   assign handshake   = (state_q == REFILL) & mem_rd_valid;
   assign last_beat   = (beat_q == OFF_W'(WORDS_PER_LINE-1));
   assign refill_done = handshake & last_beat;

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      beat_d     = beat_q;
      kill_d     = kill_q;
      inst       = 32'h0;
      inst_valid = 1'b0;
      stall      = 1'b0;
      mem_rd_req = 1'b0;
      mem_addr   = 32'h0;
      case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (hit) begin
               inst_valid = 1'b1;
               inst       = data_mem[{lk_idx, lk_off}];
            end else if (miss) begin
               stall   = 1'b1;
               line_d  = pc[31:2+OFF_W];
               beat_d  = '0;
               state_d = REFILL;
            end
         end
         REFILL: begin
            stall      = 1'b1;
            mem_rd_req = 1'b1;
            mem_addr   = {line_q, beat_q, 2'b00};
            if (flush) kill_d = 1'b1;
            if (mem_rd_valid) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         line_q     <= '0;
         beat_q     <= '0;
         kill_q     <= 1'b0;
         valid_q    <= '0;
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         beat_q  <= beat_d;
         kill_q  <= kill_d;
         // a flush landing on the final beat must also keep the line invalid
         if (flush)
            valid_q <= '0;
         else if (refill_done && !kill_q)
            valid_q[rf_idx] <= 1'b1;
         if (hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'h1;
         if (miss && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'h1;
      end
   end

   always_ff @(posedge clk) begin
      if (handshake)
         data_mem[{rf_idx, beat_q}] <= mem_rd_data;
      if (refill_done)
         tag_mem[rf_idx] <= rf_tag;
   end

endmodule

// File: tb/tb_inst_cache_responder.sv
// Directed bench for inst_cache_responder: vector table of fetches plus
// hand-written backpressure, flush and reset-during-refill sequences.
module tb_inst_cache_responder;

   logic        clk, rst_b, fetch_req, flush, mem_rd_valid;
   logic [31:0] pc, mem_rd_data;
   logic [31:0] inst, mem_addr, hit_count, miss_count;
   logic        inst_valid, stall, mem_rd_req;

   int n_cmp = 0;
   int n_err = 0;
   int mem_delay = 0;
   int wait_cnt  = 0;
   logic [31:0] addr_log[$];

   inst_cache_responder #(.LINES(16), .WORDS_PER_LINE(4)) dut (
      .clk(clk), .rst_b(rst_b), .fetch_req(fetch_req), .pc(pc), .flush(flush),
      .inst(inst), .inst_valid(inst_valid), .stall(stall),
      .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .mem_rd_valid(mem_rd_valid), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // backing memory: word at address a reads as {16'hC0DE, a[15:0]}
   initial begin
      mem_rd_valid = 0;
      mem_rd_data  = 0;
      forever begin
         @(negedge clk);
         mem_rd_valid = 0;
         if (mem_rd_req) begin
            if (wait_cnt >= mem_delay) begin
               mem_rd_valid = 1;
               mem_rd_data  = {16'hC0DE, mem_addr[15:0]};
               addr_log.push_back(mem_addr);
               wait_cnt = 0;
            end else
               wait_cnt++;
         end else
            wait_cnt = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!inst_valid && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      if (!inst_valid) timeout(name);
   endtask

   task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp,
                        input string name);
      @(negedge clk);
      fetch_req = 1;
      pc = a;
      #1;
      if (exp_hit) begin
         chk({name, " valid"}, inst_valid, 1);
         chk({name, " stall"}, stall, 0);
         chk({name, " memreq"}, mem_rd_req, 0);
         chk({name, " inst"}, inst, exp);
      end else begin
         chk({name, " miss_stall"}, stall, 1);
         chk({name, " miss_valid"}, inst_valid, 0);
         wait_valid(name);
         chk({name, " inst"}, inst, exp);
         chk({name, " stall_after"}, stall, 0);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      fetch_req = 0;
      #1;
   endtask

   typedef struct {
      logic [31:0] pc;
      bit          hit;
      logic [31:0] inst;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] exp_log[12];

   initial begin
      int n, unstable, stall_drop;
      logic        prev_req, prev_valid;
      logic [31:0] prev_addr;

      vecs[0] = '{32'h0000_0040, 0, 32'hC0DE_0040};
      vecs[1] = '{32'h0000_0044, 1, 32'hC0DE_0044};
      vecs[2] = '{32'h0000_0048, 1, 32'hC0DE_0048};
      vecs[3] = '{32'h0000_004C, 1, 32'hC0DE_004C};
      vecs[4] = '{32'h0000_0440, 0, 32'hC0DE_0440};
      vecs[5] = '{32'h0000_0040, 0, 32'hC0DE_0040};
      exp_log = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h440, 32'h444, 32'h448, 32'h44C,
                  32'h40, 32'h44, 32'h48, 32'h4C};

      rst_b = 0; fetch_req = 0; flush = 0; pc = 0;
      #3;
      chk("rst stall", stall, 0);
      chk("rst inst_valid", inst_valid, 0);
      chk("rst inst", inst, 0);
      chk("rst mem_rd_req", mem_rd_req, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst hit_count", hit_count, 0);
      chk("rst miss_count", miss_count, 0);
      @(negedge clk);
      rst_b = 1;

      // cold miss, line hits, conflict eviction
      for (int i = 0; i < 6; i++) begin
         fetch(vecs[i].pc, vecs[i].hit, vecs[i].inst, $sformatf("vec%0d", i));
         if (i == 3) begin
            idle_cycle();
            chk("t1 miss_count", miss_count, 1);
            chk("t2 hit_count", hit_count, 4);
         end
      end
      idle_cycle();
      chk("t3 miss_count", miss_count, 3);
      chk("t3 hit_count", hit_count, 6);
      chk("t3 log size", addr_log.size(), 12);
      for (int i = 0; i < 12 && i < addr_log.size(); i++)
         chk($sformatf("log addr%0d", i), addr_log[i], exp_log[i]);

      // memory backpressure: 5 idle cycles per beat
      mem_delay = 5;
      addr_log.delete();
      @(negedge clk);
      fetch_req = 1; pc = 32'h80;
      #1;
      chk("t4 miss stall", stall, 1);
      n = 0; unstable = 0; stall_drop = 0;
      while (!inst_valid && n < 400) begin
         prev_req = mem_rd_req; prev_addr = mem_addr; prev_valid = mem_rd_valid;
         @(negedge clk); #1;
         n++;
         if (!inst_valid && !stall) stall_drop++;
         if (prev_req && !prev_valid && mem_rd_req && mem_addr !== prev_addr) unstable++;
      end
      if (!inst_valid) timeout("t4 refill");
      chk("t4 latency", n, 25);
      chk("t4 addr unstable", unstable, 0);
      chk("t4 stall dropped", stall_drop, 0);
      chk("t4 inst", inst, 32'hC0DE_0080);
      chk("t4 log size", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         chk($sformatf("t4 addr%0d", i), addr_log[i], 32'h80 + 32'(4*i));
      fetch(32'h8C, 1, 32'hC0DE_008C, "t4 hit");
      mem_delay = 0;

      // flush on beat 2 of a refill kills the line
      @(negedge clk);
      fetch_req = 1; pc = 32'hC0;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mem_rd_req && mem_addr == 32'hC8) && n < 50);
      if (!(mem_rd_req && mem_addr == 32'hC8)) timeout("t5 beat2");
      flush = 1;
      @(negedge clk);
      flush = 0;
      #1;
      n = 0;
      while (mem_rd_req && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (mem_rd_req) timeout("t5 refill end");
      chk("t5 killed stall", stall, 1);
      chk("t5 killed valid", inst_valid, 0);
      wait_valid("t5 rerefill");
      chk("t5 inst", inst, 32'hC0DE_00C0);
      fetch(32'h40, 0, 32'hC0DE_0040, "t5 40 after flush");
      fetch(32'hC4, 1, 32'hC0DE_00C4, "t5 C4");
      fetch(32'h44, 1, 32'hC0DE_0044, "t5 44");

      // flush in IDLE: same-cycle lookup still hits, then everything misses
      @(negedge clk);
      pc = 32'hC8; fetch_req = 1; flush = 1;
      #1;
      chk("t5 flush-cycle valid", inst_valid, 1);
      chk("t5 flush-cycle inst", inst, 32'hC0DE_00C8);
      @(negedge clk);
      flush = 0; fetch_req = 0;
      fetch(32'hC8, 0, 32'hC0DE_00C8, "t5 C8 post flush");
      fetch(32'h48, 0, 32'hC0DE_0048, "t5 48 post flush");

      // reset in the middle of a refill
      @(negedge clk);
      fetch_req = 1; pc = 32'h100;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mem_rd_req && mem_addr == 32'h104) && n < 50);
      if (!(mem_rd_req && mem_addr == 32'h104)) timeout("t6 beat1");
      rst_b = 0;
      #1;
      chk("t6 stall", stall, 0);
      chk("t6 inst_valid", inst_valid, 0);
      chk("t6 inst", inst, 0);
      chk("t6 mem_rd_req", mem_rd_req, 0);
      chk("t6 mem_addr", mem_addr, 0);
      chk("t6 hit_count", hit_count, 0);
      chk("t6 miss_count", miss_count, 0);
      fetch_req = 0;
      @(negedge clk);
      rst_b = 1;
      addr_log.delete();
      fetch(32'h40, 0, 32'hC0DE_0040, "t6 40");
      fetch(32'h100, 0, 32'hC0DE_0100, "t6 100");
      chk("t6 log size", addr_log.size(), 8);
      if (addr_log.size() == 8) begin
         chk("t6 first addr", addr_log[0], 32'h40);
         chk("t6 refill beat0", addr_log[4], 32'h100);
         chk("t6 refill beat3", addr_log[7], 32'h10C);
      end
      idle_cycle();
      chk("t6 miss_count", miss_count, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
